// File: rtl/muldiv_pkg.sv
// Shared types and op-decode helpers for the iterative multiply/divide unit.
package muldiv_pkg;

    // Encoding matches the M-extension funct3 field.
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_div(input muldiv_op_t op);
        logic [2:0] code;
        code = op;
        return code[2];
    endfunction

    function automatic logic is_rem(input muldiv_op_t op);
        logic [2:0] code;
        code = op;
        return code[2] & code[1];
    endfunction

    function automatic logic is_signed_rs1(input muldiv_op_t op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_rs2(input muldiv_op_t op);
        return (op == OP_MUL) || (op == OP_MULH) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-BITS_PER_CYCLE iteration: shift-add multiply or restoring divide.
// Multiply: hi = partial product, lo = multiplier shifting right.
// Divide:   hi = partial remainder, lo = dividend shifting out / quotient in.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN           = 64,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic            div_mode,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] operand,
    output logic [XLEN-1:0] hi_next,
    output logic [XLEN-1:0] lo_next
);

    logic [XLEN-1:0] acc_hi;
    logic [XLEN-1:0] acc_lo;
    logic [XLEN:0]   part;
    logic [XLEN:0]   diff;
    logic [XLEN:0]   sum;

    // Unrolled bit steps; the divide borrow bit doubles as the quotient bit.
    always_comb begin
        acc_hi = hi;
        acc_lo = lo;
        part   = '0;
        diff   = '0;
        sum    = '0;
        for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
            if (div_mode) begin
                part   = {acc_hi, acc_lo[XLEN-1]};
                diff   = part - {1'b0, operand};
                acc_lo = {acc_lo[XLEN-2:0], ~diff[XLEN]};
                acc_hi = diff[XLEN] ? part[XLEN-1:0] : diff[XLEN-1:0];
            end else begin
                sum    = acc_lo[0] ? ({1'b0, acc_hi} + {1'b0, operand}) : {1'b0, acc_hi};
                acc_lo = {sum[0], acc_lo[XLEN-1:1]};
                acc_hi = sum[XLEN:1];
            end
        end
        hi_next = acc_hi;
        lo_next = acc_lo;
    end

endmodule

// File: rtl/execute_muldiv.sv
// Iterative M-extension multiply/divide unit for the execute stage.
// Optional feature macro: MULDIV_W_EN (adds the 32-bit *W ops, XLEN=64 only).
module execute_muldiv
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN           = 64,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_in,
    input  logic            flush_in,
    input  logic            valid_in,
    input  logic [2:0]      op_in,
    input  logic            word_in,
    input  logic [XLEN-1:0] rs1_value_in,
    input  logic [XLEN-1:0] rs2_value_in,
    output logic            busy_out,
    output logic            valid_out,
    output logic [XLEN-1:0] result_out
);

    localparam int unsigned ITERS = XLEN / BITS_PER_CYCLE;
    localparam int unsigned CNT_W = $clog2(ITERS + 1);
    localparam int unsigned PW    = 2 * XLEN;
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state, state_next;
    muldiv_op_t      op_e, op_q;
    logic            accept;
    logic            signed1, signed2, neg1, neg2, div0, ovf, special;
    logic [XLEN-1:0] a_ext, b_ext, min_val, mag1, mag2, special_res;
    logic [CNT_W-1:0] iters;
    logic            neg1_q, neg2_q;
    logic [XLEN-1:0] operand_q, hi_q, lo_q, hi_n, lo_n;
    logic [CNT_W-1:0] count_q;
    logic [XLEN-1:0] result_q, calc_res, mul_res, quo_s, rem_s;
    logic [PW-1:0]   prod, prod_s;
    logic            valid_q;

`ifdef MULDIV_W_EN
    localparam int unsigned ITERS_W = 32 / BITS_PER_CYCLE;
    logic word_q;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction
`else
    logic unused_word;
    assign unused_word = word_in;
`endif

    assign accept = valid_in && !flush_in &&
                    ((state == IDLE) || ((state == DONE) && !stall_in));

    // Decode the incoming request: operand extension, magnitudes, corner cases.
    always_comb begin
        op_e    = muldiv_op_t'(op_in);
        signed1 = is_signed_rs1(op_e);
        signed2 = is_signed_rs2(op_e);
        a_ext   = rs1_value_in;
        b_ext   = rs2_value_in;
        min_val = MIN_VAL;
        iters   = CNT_W'(ITERS);
`ifdef MULDIV_W_EN
        if (word_in) begin
            a_ext   = signed1 ? sext32(rs1_value_in[31:0]) : XLEN'(rs1_value_in[31:0]);
            b_ext   = signed2 ? sext32(rs2_value_in[31:0]) : XLEN'(rs2_value_in[31:0]);
            min_val = sext32(32'h8000_0000);
            iters   = CNT_W'(ITERS_W);
        end
`endif
        neg1    = signed1 & a_ext[XLEN-1];
        neg2    = signed2 & b_ext[XLEN-1];
        mag1    = neg1 ? (~a_ext + XLEN'(1)) : a_ext;
        mag2    = neg2 ? (~b_ext + XLEN'(1)) : b_ext;
        div0    = is_div(op_e) && (b_ext == '0);
        ovf     = is_div(op_e) && signed1 && (a_ext == min_val) && (b_ext == '1);
        special = div0 | ovf;
        if (is_rem(op_e)) begin
            special_res = div0 ? a_ext : '0;
        end else begin
            special_res = div0 ? '1 : a_ext;
        end
`ifdef MULDIV_W_EN
        if (word_in) begin
            special_res = sext32(special_res[31:0]);
        end
`endif
    end

    muldiv_step #(
        .XLEN           (XLEN),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .div_mode (is_div(op_q)),
        .hi       (hi_q),
        .lo       (lo_q),
        .operand  (operand_q),
        .hi_next  (hi_n),
        .lo_next  (lo_n)
    );

    // Sign fix-up and result selection applied to the final step's output.
    always_comb begin
        prod = {hi_n, lo_n};
`ifdef MULDIV_W_EN
        if (word_q) begin
            prod = prod >> 32;
        end
`endif
        prod_s   = (neg1_q ^ neg2_q) ? (~prod + PW'(1)) : prod;
        mul_res  = (op_q == OP_MUL) ? prod_s[XLEN-1:0] : prod_s[PW-1:XLEN];
        quo_s    = (neg1_q ^ neg2_q) ? (~lo_n + XLEN'(1)) : lo_n;
        rem_s    = neg1_q ? (~hi_n + XLEN'(1)) : hi_n;
        calc_res = is_div(op_q) ? (is_rem(op_q) ? rem_s : quo_s) : mul_res;
`ifdef MULDIV_W_EN
        if (word_q) begin
            calc_res = sext32(calc_res[31:0]);
        end
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; flush overrides everything.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = special ? DONE : CALC;
            CALC: if (count_q == CNT_W'(1)) state_next = DONE;
            DONE: if (!stall_in) state_next = accept ? (special ? DONE : CALC) : IDLE;
            default: state_next = IDLE;
        endcase
        if (flush_in) begin
            state_next = IDLE;
        end
    end

    // Stall request toward the front of the pipe.
    always_comb begin
        busy_out = 1'b0;
        case (state)
            IDLE:    busy_out = valid_in;
            CALC:    busy_out = 1'b1;
            DONE:    busy_out = valid_in & ~stall_in;
            default: busy_out = 1'b0;
        endcase
    end

    // Operand capture, iteration datapath and result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q      <= OP_MUL;
            neg1_q    <= 1'b0;
            neg2_q    <= 1'b0;
            operand_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            count_q   <= '0;
            result_q  <= '0;
            valid_q   <= 1'b0;
`ifdef MULDIV_W_EN
            word_q    <= 1'b0;
`endif
        end else begin
            valid_q <= (state_next == DONE);
            if (flush_in) begin
                count_q <= '0;
            end else if (accept) begin
                op_q      <= op_e;
                neg1_q    <= neg1;
                neg2_q    <= neg2;
                operand_q <= is_div(op_e) ? mag2 : mag1;
                hi_q      <= '0;
                lo_q      <= is_div(op_e) ? mag1 : mag2;
                count_q   <= special ? '0 : iters;
`ifdef MULDIV_W_EN
                word_q    <= word_in;
                if (word_in && is_div(op_e)) begin
                    lo_q <= mag1 << 32;
                end
`endif
                if (special) begin
                    result_q <= special_res;
                end
            end else if (state == CALC) begin
                hi_q    <= hi_n;
                lo_q    <= lo_n;
                count_q <= count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    result_q <= calc_res;
                end
            end
        end
    end

    assign valid_out  = valid_q;
    assign result_out = result_q;

endmodule

// File: tb/tb_execute_muldiv.sv
// Bench for execute_muldiv: radix 1, 2 and 4 instances share one stimulus stream.
module tb_execute_muldiv;
    import muldiv_pkg::*;

    localparam int unsigned XLEN = 64;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        reset, stall_in, flush_in, valid_in, word_in;
    logic [2:0]  op_in;
    logic [63:0] rs1, rs2;
    logic        busy1, valid1, busy2, valid2, busy4, valid4;
    logic [63:0] res1, res2, res4;

    always #5 clk = ~clk;

    execute_muldiv #(.XLEN(XLEN), .BITS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .reset(reset), .stall_in(stall_in), .flush_in(flush_in),
        .valid_in(valid_in), .op_in(op_in), .word_in(word_in),
        .rs1_value_in(rs1), .rs2_value_in(rs2),
        .busy_out(busy1), .valid_out(valid1), .result_out(res1));

    execute_muldiv #(.XLEN(XLEN), .BITS_PER_CYCLE(2)) u_dut2 (
        .clk(clk), .reset(reset), .stall_in(stall_in), .flush_in(flush_in),
        .valid_in(valid_in), .op_in(op_in), .word_in(word_in),
        .rs1_value_in(rs1), .rs2_value_in(rs2),
        .busy_out(busy2), .valid_out(valid2), .result_out(res2));

    execute_muldiv #(.XLEN(XLEN), .BITS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .reset(reset), .stall_in(stall_in), .flush_in(flush_in),
        .valid_in(valid_in), .op_in(op_in), .word_in(word_in),
        .rs1_value_in(rs1), .rs2_value_in(rs2),
        .busy_out(busy4), .valid_out(valid4), .result_out(res4));

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic        word;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic        special;
    } vec_t;

    typedef struct {
        logic [63:0] res;
        int          lat1;
        int          lat2;
        int          lat4;
    } exp_t;

    exp_t scoreboard[$];
    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [2:0] op, input logic word,
                                input logic [63:0] a, input logic [63:0] b,
                                input logic [63:0] res, input logic special);
        vec_t v;
        v.name = name; v.op = op; v.word = word; v.a = a; v.b = b;
        v.res = res; v.special = special;
        return v;
    endfunction

    function automatic int lat_for(input int bpc, input logic word, input logic special);
        if (special) return 1;
        return (word ? 32 : 64) / bpc + 1;
    endfunction

    // Reference built on native wide arithmetic.
    function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [63:0] a,
                                              input logic [63:0] b);
        logic [127:0]       ea, eb, p;
        logic signed [63:0] sa, sbv;
        logic [63:0]        r;
        ea = {{64{a[63]}}, a};
        eb = {{64{b[63]}}, b};
        sa = a; sbv = b;
        p = '0;
        r = '0;
        case (op)
            3'd0: r = a * b;
            3'd1: begin p = ea * eb; r = p[127:64]; end
            3'd2: begin p = ea * {64'd0, b}; r = p[127:64]; end
            3'd3: begin p = {64'd0, a} * {64'd0, b}; r = p[127:64]; end
            3'd4: r = (b == 0) ? ONES : ((a == MINV && b == ONES) ? a : 64'(sa / sbv));
            3'd5: r = (b == 0) ? ONES : a / b;
            3'd6: r = (b == 0) ? a : ((a == MINV && b == ONES) ? 64'd0 : 64'(sa % sbv));
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Drive one op at the current cycle (state IDLE or DONE) and check all instances.
    task automatic issue(input vec_t v);
        exp_t e;
        int   cyc, nb, l2, l4;
        logic [63:0] r2, r4;
        e.res  = v.res;
        e.lat1 = lat_for(1, v.word, v.special);
        e.lat2 = lat_for(2, v.word, v.special);
        e.lat4 = lat_for(4, v.word, v.special);
        scoreboard.push_back(e);
        op_in = v.op; word_in = v.word; rs1 = v.a; rs2 = v.b; valid_in = 1'b1;
        #1;
        check({v.name, "_busy0"}, 64'(busy1), 64'd1);
        @(posedge clk); #1;
        valid_in = 1'b0;
        rs1 = {$urandom, $urandom};
        rs2 = {$urandom, $urandom};
        op_in = 3'($urandom_range(0, 7));
        cyc = 1; nb = 0; l2 = 0; l4 = 0; r2 = '0; r4 = '0;
        while (cyc < 300) begin
            if (l2 == 0 && valid2) begin l2 = cyc; r2 = res2; end
            if (l4 == 0 && valid4) begin l4 = cyc; r4 = res4; end
            if (valid1) break;
            if (busy1) nb++;
            @(posedge clk); #1;
            cyc++;
        end
        check({v.name, "_valid"}, 64'(valid1), 64'd1);
        e = scoreboard.pop_front();
        check({v.name, "_res"}, res1, e.res);
        check({v.name, "_lat"}, 64'(cyc), 64'(e.lat1));
        check({v.name, "_busycyc"}, 64'(nb), 64'(e.lat1 - 1));
        check({v.name, "_res_r2"}, r2, e.res);
        check({v.name, "_lat_r2"}, 64'(l2), 64'(e.lat2));
        check({v.name, "_res_r4"}, r4, e.res);
        check({v.name, "_lat_r4"}, 64'(l4), 64'(e.lat4));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nvalid;
        vec_t v;
        logic [63:0] a, b;
        logic [2:0]  op;

        reset = 1'b1; stall_in = 1'b0; flush_in = 1'b0; valid_in = 1'b0;
        word_in = 1'b0; op_in = 3'd0; rs1 = '0; rs2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", 64'(valid1), 64'd0);
        check("reset_result", res1, 64'd0);
        check("reset_busy", 64'(busy1), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        vecs.push_back(mk("mul_7_m3",     3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0));
        vecs.push_back(mk("mulhu_ones",   3'd3, 1'b0, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0));
        vecs.push_back(mk("mulh_ones",    3'd1, 1'b0, ONES, ONES, 64'd0, 1'b0));
        vecs.push_back(mk("mulhsu_ones",  3'd2, 1'b0, ONES, ONES, ONES, 1'b0));
        vecs.push_back(mk("div_m20_3",    3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0));
        vecs.push_back(mk("rem_m20_3",    3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0));
        vecs.push_back(mk("divu_100_7",   3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 1'b0));
        vecs.push_back(mk("remu_100_7",   3'd7, 1'b0, 64'd100, 64'd7, 64'd2, 1'b0));
        vecs.push_back(mk("div_5_0",      3'd4, 1'b0, 64'd5, 64'd0, ONES, 1'b1));
        vecs.push_back(mk("rem_5_0",      3'd6, 1'b0, 64'd5, 64'd0, 64'd5, 1'b1));
        vecs.push_back(mk("divu_5_0",     3'd5, 1'b0, 64'd5, 64'd0, ONES, 1'b1));
        vecs.push_back(mk("remu_5_0",     3'd7, 1'b0, 64'd5, 64'd0, 64'd5, 1'b1));
        vecs.push_back(mk("div_ovf",      3'd4, 1'b0, MINV, ONES, MINV, 1'b1));
        vecs.push_back(mk("rem_ovf",      3'd6, 1'b0, MINV, ONES, 64'd0, 1'b1));
        vecs.push_back(mk("divu_min_m1",  3'd5, 1'b0, MINV, ONES, 64'd0, 1'b0));
        vecs.push_back(mk("remu_min_m1",  3'd7, 1'b0, MINV, ONES, MINV, 1'b0));
        vecs.push_back(mk("mul_min_2",    3'd0, 1'b0, MINV, 64'd2, 64'd0, 1'b0));
        vecs.push_back(mk("rem_7_m2",     3'd6, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 1'b0));
`ifdef MULDIV_W_EN
        vecs.push_back(mk("divw_ovf",     3'd4, 1'b1, 64'h0000_0001_8000_0000, ONES, 64'hFFFF_FFFF_8000_0000, 1'b1));
        vecs.push_back(mk("mulw_3_m2",    3'd0, 1'b1, 64'h0000_0001_0000_0003, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0));
        vecs.push_back(mk("divuw_100_7",  3'd5, 1'b1, 64'hFFFF_FFFF_0000_0064, 64'd7, 64'd14, 1'b0));
        vecs.push_back(mk("remw_m20_3",   3'd6, 1'b1, 64'h0000_0000_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0));
        vecs.push_back(mk("remuw_x_0",    3'd7, 1'b1, 64'h0000_0000_8000_0005, 64'h1_0000_0000, 64'hFFFF_FFFF_8000_0005, 1'b1));
`endif

        // Table vectors; odd entries are issued back-to-back from DONE.
        for (int i = 0; i < vecs.size(); i++) begin
            if (i % 2 == 0) begin
                @(posedge clk); #1;
            end
            issue(vecs[i]);
        end

        // Random operands checked against the native-arithmetic reference.
        for (int i = 0; i < 12; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = {$urandom, $urandom};
            b  = (i % 4 == 3) ? 64'd0 : ((i % 3 == 0) ? 64'($urandom_range(1, 1000)) : {$urandom, $urandom});
            v  = mk($sformatf("rand%0d", i), op, 1'b0, a, b, ref_model(op, a, b),
                    op[2] && (b == 0 || ((op == 3'd4 || op == 3'd6) && a == MINV && b == ONES)));
            issue(v);
        end

        // Flush at cycle 20 of a divide: nothing comes out, unit idles.
        @(posedge clk); #1;
        op_in = 3'd4; word_in = 1'b0; rs1 = 64'd1000; rs2 = 64'd7; valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        repeat (19) begin @(posedge clk); #1; end
        flush_in = 1'b1;
        @(posedge clk); #1;
        flush_in = 1'b0;
        check("flush_busy", 64'(busy1), 64'd0);
        check("flush_valid", 64'(valid1), 64'd0);
        check("flush_busy_r2", 64'(busy2), 64'd0);
        nvalid = 0;
        repeat (80) begin
            @(posedge clk); #1;
            if (valid1 || valid2 || valid4) nvalid++;
        end
        check("flush_no_result", 64'(nvalid), 64'd0);
        issue(mk("mul_after_flush", 3'd0, 1'b0, 64'd123456789, 64'd1000, 64'd123456789000, 1'b0));

        // Stall held three cycles in DONE keeps the result, then returns to IDLE.
        @(posedge clk); #1;
        issue(mk("mul_stall", 3'd0, 1'b0, 64'd3, 64'd5, 64'd15, 1'b0));
        stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("stall_valid%0d", i), 64'(valid1), 64'd1);
            check($sformatf("stall_res%0d", i), res1, 64'd15);
        end
        stall_in = 1'b0;
        @(posedge clk); #1;
        check("post_stall_valid", 64'(valid1), 64'd0);
        check("post_stall_busy", 64'(busy1), 64'd0);

        // Reset in the middle of an operation clears everything.
        op_in = 3'd0; rs1 = 64'd9; rs2 = 64'd9; valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midreset_valid", 64'(valid1), 64'd0);
        check("midreset_busy", 64'(busy1), 64'd0);
        check("midreset_res", res1, 64'd0);
        check("midreset_res_r4", res4, 64'd0);
        @(posedge clk); #1;
        issue(mk("divu_after_reset", 3'd5, 1'b0, 64'd1_000_000, 64'd3, 64'd333_333, 1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
